// File: rtl/rot_pkg.sv
// Shared types for the image-rotate sequencer: FSM states, rotation codes, rotation helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_DATA = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      ROT_0   = 2'd0,
      ROT_90  = 2'd1,
      ROT_180 = 2'd2,
      ROT_270 = 2'd3
   } rot_t;

   // CCW by MODE quarter-turns is the same as CW by (4-MODE) mod 4 quarter-turns
   function automatic rot_t eff_rot(input logic [1:0] mode, input logic dir);
      logic [1:0] neg;
      neg = 2'd0 - mode;
      return dir ? rot_t'(neg) : rot_t'(mode);
   endfunction

   // Quarter-turn rotations exchange the image height and width
   function automatic logic swaps_dims(input rot_t rot);
      return (rot == ROT_90) || (rot == ROT_270);
   endfunction

endpackage

// File: rtl/rot_seq_ctrl_if.sv
// DMA-side bundle of the rotate sequencer: read-address, read-data and write channels.
// Latency: n/a (wires only).
// Backpressure: rd_ready / wr_ready from the DMA port stall the sequencer.
interface rot_seq_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              rd_valid;
   logic              rd_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_dvalid;
   logic [DATA_W-1:0] rd_data;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      output rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
      input  rd_ready, rd_dvalid, rd_data, wr_ready
   );

   modport slave (
      input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
      output rd_ready, rd_dvalid, rd_data, wr_ready
   );
endinterface

// File: rtl/rot_addr_gen.sv
// Maps a source pixel (row, col) to its source read address and rotated destination address.
// Latency: purely combinational.
// Backpressure: none; inputs are held stable by the sequencer while a request waits.
module rot_addr_gen
   import rot_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int PIX_BYTES = 4
) (
   input  logic [15:0]       row_i,
   input  logic [15:0]       col_i,
   input  logic [15:0]       h_i,
   input  logic [15:0]       w_i,
   input  logic [15:0]       new_w_i,
   input  rot_t              rot_i,
   input  logic [ADDR_W-1:0] src_i,
   input  logic [ADDR_W-1:0] dst_i,
   output logic [ADDR_W-1:0] rd_addr_o,
   output logic [ADDR_W-1:0] wr_addr_o
);

   logic [15:0] dst_row;
   logic [15:0] dst_col;
   logic [31:0] rd_off;
   logic [31:0] wr_off;

   // Destination coordinates of the current source pixel for each rotation
   always_comb begin
      dst_row = row_i;
      dst_col = col_i;
      case (rot_i)
         ROT_90: begin
            dst_row = col_i;
            dst_col = h_i - 16'd1 - row_i;
         end
         ROT_180: begin
            dst_row = h_i - 16'd1 - row_i;
            dst_col = w_i - 16'd1 - col_i;
         end
         ROT_270: begin
            dst_row = w_i - 16'd1 - col_i;
            dst_col = row_i;
         end
         default: begin
            dst_row = row_i;
            dst_col = col_i;
         end
      endcase
   end

   // Byte offsets use 32-bit products; overflow silently wraps
   always_comb begin
      rd_off = (32'(row_i) * 32'(w_i) + 32'(col_i)) * 32'(PIX_BYTES);
      wr_off = (32'(dst_row) * 32'(new_w_i) + 32'(dst_col)) * 32'(PIX_BYTES);
   end

   assign rd_addr_o = src_i + ADDR_W'(rd_off);
   assign wr_addr_o = dst_i + ADDR_W'(wr_off);

endmodule

// File: rtl/rot_seq_ctrl.sv
// Rotate sequencer: per source pixel, one DMA read then one DMA write to the rotated address.
// Latency: start edge -> first read request 1 cycle; DONE 1 cycle after the last write is accepted.
// Backpressure: rd_ready/wr_ready stall with address/data held; ROT_PERF_CNT_EN adds O_PERF_CYCLES.
module rot_seq_ctrl
   import rot_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int PIX_BYTES = 4
) (
   input  logic              I_PCLK,
   input  logic              I_PRESET_N,
   input  logic              I_CTRL_START,
   input  logic              I_CTRL_RESET,
   input  logic              I_CTRL_INTR_MASK,
   input  logic              I_CTRL_INTR_CLEAR,
   input  logic [ADDR_W-1:0] I_DMA_SRC_IMG,
   input  logic [ADDR_W-1:0] I_DMA_DST_IMG,
   input  logic [15:0]       I_ROT_IMG_H,
   input  logic [15:0]       I_ROT_IMG_W,
   input  logic [1:0]        I_ROT_IMG_MODE,
   input  logic              I_ROT_IMG_DIR,
   rot_seq_ctrl_if.master    dma,
   output logic [15:0]       O_ROT_IMG_NEW_H,
   output logic [15:0]       O_ROT_IMG_NEW_W,
   output logic              O_CTRL_BUSY,
   output logic              O_CTRL_BEF_MASK,
   output logic              O_CTRL_AFT_MASK
`ifdef ROT_PERF_CNT_EN
   ,
   output logic [31:0]       O_PERF_CYCLES
`endif
);

   state_t            state_q;
   logic              start_q;
   logic              busy_q;
   logic              bef_q;
   logic              rd_vld_q;
   logic              wr_vld_q;
   logic              drop_q;
   logic [15:0]       row_q;
   logic [15:0]       col_q;
   logic [15:0]       h_q;
   logic [15:0]       w_q;
   logic [15:0]       new_h_q;
   logic [15:0]       new_w_q;
   rot_t              rot_q;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [DATA_W-1:0] wr_dat_q;

   logic [15:0]       row_d;
   logic [15:0]       col_d;
   logic              last_pix;
   logic              start_acc;
   logic              rd_in_flight;
   rot_t              rot_in;

   assign rot_in    = eff_rot(I_ROT_IMG_MODE, I_ROT_IMG_DIR);
   assign start_acc = (state_q == ST_IDLE) && I_CTRL_START && !start_q && !I_CTRL_RESET;
   assign last_pix  = (row_q == h_q - 16'd1) && (col_q == w_q - 16'd1);
   // A read accepted but not yet returned must have its beat discarded after an abort
   assign rd_in_flight = ((state_q == ST_RD_REQ) && dma.rd_ready) ||
                         ((state_q == ST_RD_DATA) && !dma.rd_dvalid);

   // Row-major walk: step the column, wrap into the next row
   always_comb begin
      row_d = row_q;
      col_d = col_q + 16'd1;
      if (col_q == w_q - 16'd1) begin
         col_d = 16'd0;
         row_d = row_q + 16'd1;
      end
   end

   rot_addr_gen #(
      .ADDR_W    (ADDR_W),
      .PIX_BYTES (PIX_BYTES)
   ) u_addr_gen (
      .row_i     (row_q),
      .col_i     (col_q),
      .h_i       (h_q),
      .w_i       (w_q),
      .new_w_i   (new_w_q),
      .rot_i     (rot_q),
      .src_i     (src_q),
      .dst_i     (dst_q),
      .rd_addr_o (dma.rd_addr),
      .wr_addr_o (dma.wr_addr)
   );

   // Sequencer FSM with its counters, handshake flags and done status
   always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
      if (!I_PRESET_N) begin
         state_q  <= ST_IDLE;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         bef_q    <= 1'b0;
         rd_vld_q <= 1'b0;
         wr_vld_q <= 1'b0;
         drop_q   <= 1'b0;
         row_q    <= '0;
         col_q    <= '0;
         h_q      <= '0;
         w_q      <= '0;
         new_h_q  <= '0;
         new_w_q  <= '0;
         rot_q    <= ROT_0;
         src_q    <= '0;
         dst_q    <= '0;
         wr_dat_q <= '0;
      end else begin
         start_q <= I_CTRL_START;

         // Done sets the sticky status and beats a same-cycle clear
         if ((state_q == ST_DONE) && !I_CTRL_RESET) begin
            bef_q <= 1'b1;
         end else if (I_CTRL_INTR_CLEAR) begin
            bef_q <= 1'b0;
         end

         if (I_CTRL_RESET && rd_in_flight) begin
            drop_q <= 1'b1;
         end else if (drop_q && dma.rd_dvalid) begin
            drop_q <= 1'b0;
         end

         if (I_CTRL_RESET) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            wr_vld_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start_acc) begin
                     h_q     <= I_ROT_IMG_H;
                     w_q     <= I_ROT_IMG_W;
                     rot_q   <= rot_in;
                     src_q   <= I_DMA_SRC_IMG;
                     dst_q   <= I_DMA_DST_IMG;
                     new_h_q <= swaps_dims(rot_in) ? I_ROT_IMG_W : I_ROT_IMG_H;
                     new_w_q <= swaps_dims(rot_in) ? I_ROT_IMG_H : I_ROT_IMG_W;
                     row_q   <= '0;
                     col_q   <= '0;
                     busy_q  <= 1'b1;
                     if ((I_ROT_IMG_H == 16'd0) || (I_ROT_IMG_W == 16'd0)) begin
                        state_q <= ST_DONE;
                     end else begin
                        state_q  <= ST_RD_REQ;
                        rd_vld_q <= 1'b1;
                     end
                  end
               end
               ST_RD_REQ: begin
                  if (dma.rd_ready) begin
                     rd_vld_q <= 1'b0;
                     state_q  <= ST_RD_DATA;
                  end
               end
               ST_RD_DATA: begin
                  if (dma.rd_dvalid && !drop_q) begin
                     wr_dat_q <= dma.rd_data;
                     wr_vld_q <= 1'b1;
                     state_q  <= ST_WR_REQ;
                  end
               end
               ST_WR_REQ: begin
                  if (dma.wr_ready) begin
                     wr_vld_q <= 1'b0;
                     if (last_pix) begin
                        state_q <= ST_DONE;
                     end else begin
                        row_q    <= row_d;
                        col_q    <= col_d;
                        rd_vld_q <= 1'b1;
                        state_q  <= ST_RD_REQ;
                     end
                  end
               end
               ST_DONE: begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign dma.rd_valid    = rd_vld_q;
   assign dma.wr_valid    = wr_vld_q;
   assign dma.wr_data     = wr_dat_q;
   assign O_ROT_IMG_NEW_H = new_h_q;
   assign O_ROT_IMG_NEW_W = new_w_q;
   assign O_CTRL_BUSY     = busy_q;
   assign O_CTRL_BEF_MASK = bef_q;
   assign O_CTRL_AFT_MASK = bef_q & ~I_CTRL_INTR_MASK;

`ifdef ROT_PERF_CNT_EN
   logic [31:0] perf_q;

   // Busy-cycle counter: restarts on each accepted start, saturates, holds when idle
   always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
      if (!I_PRESET_N) begin
         perf_q <= '0;
      end else if (start_acc) begin
         perf_q <= '0;
      end else if (busy_q && (perf_q != '1)) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign O_PERF_CYCLES = perf_q;
`endif

endmodule

// File: tb/tb_rot_seq_ctrl.sv
// Randomised bench for rot_seq_ctrl: DMA slave with random ready/latency, queue-based reference.
// Latency: n/a.
// Backpressure: random and forced READY stalls on both DMA channels.
module tb_rot_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        soft_rst = 1'b0;
   logic        mask = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] src = '0;
   logic [31:0] dst = '0;
   logic [15:0] h = '0;
   logic [15:0] w = '0;
   logic [1:0]  mode = '0;
   logic        dir = 1'b0;
   logic [15:0] new_h;
   logic [15:0] new_w;
   logic        busy;
   logic        bef;
   logic        aft;

   int          n_checks = 0;
   int          n_errs = 0;
   logic [31:0] first_wr;
   int          last_nrd;
   int          last_nwr;

   rot_seq_ctrl_if #(.ADDR_W(32), .DATA_W(32)) dma_if ();

   rot_seq_ctrl #(.DATA_W(32), .ADDR_W(32), .PIX_BYTES(4)) dut (
      .I_PCLK            (clk),
      .I_PRESET_N        (rst_n),
      .I_CTRL_START      (start),
      .I_CTRL_RESET      (soft_rst),
      .I_CTRL_INTR_MASK  (mask),
      .I_CTRL_INTR_CLEAR (clr),
      .I_DMA_SRC_IMG     (src),
      .I_DMA_DST_IMG     (dst),
      .I_ROT_IMG_H       (h),
      .I_ROT_IMG_W       (w),
      .I_ROT_IMG_MODE    (mode),
      .I_ROT_IMG_DIR     (dir),
      .dma               (dma_if),
      .O_ROT_IMG_NEW_H   (new_h),
      .O_ROT_IMG_NEW_W   (new_w),
      .O_CTRL_BUSY       (busy),
      .O_CTRL_BEF_MASK   (bef),
      .O_CTRL_AFT_MASK   (aft)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pixel contents of source memory, a hash of the address
   function automatic logic [31:0] pix_data(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
   endfunction

   // Destination address of source pixel (r,c) after a clockwise turn of deg degrees
   function automatic logic [31:0] ref_wr_addr(input int r, input int c, input int hh,
                                                input int ww, input int deg,
                                                input logic [31:0] base);
      int dr, dc, nw;
      case (deg)
         90:      begin dr = c;          dc = hh - 1 - r; nw = hh; end
         180:     begin dr = hh - 1 - r; dc = ww - 1 - c; nw = ww; end
         270:     begin dr = ww - 1 - c; dc = r;          nw = hh; end
         default: begin dr = r;          dc = c;          nw = ww; end
      endcase
      return base + 32'((dr * nw + dc) * 4);
   endfunction

   task automatic run_job(input int hh, input int ww, input logic [1:0] md, input logic dd,
                          input logic [31:0] sb, input logic [31:0] db,
                          input int abort_at, input int stall, input bit hold_clr);
      logic [31:0] exp_rd[$];
      logic [31:0] exp_wr[$];
      logic [31:0] exp_dat[$];
      logic [31:0] beat_q[$];
      int          lat_q[$];
      int          deg, total, budget, cyc, nrd, nwr, vld_cycles, rstall, wstall;
      bit          fin, aborted, rd_wait, wr_wait, rdy;
      logic [31:0] prev_rd_addr, prev_wr_addr, prev_wr_dat;

      deg   = dd ? (360 - 90 * int'(md)) % 360 : 90 * int'(md);
      total = hh * ww;
      for (int r = 0; r < hh; r++) begin
         for (int c = 0; c < ww; c++) begin
            exp_rd.push_back(sb + 32'((r * ww + c) * 4));
            exp_wr.push_back(ref_wr_addr(r, c, hh, ww, deg, db));
            exp_dat.push_back(pix_data(sb + 32'((r * ww + c) * 4)));
         end
      end

      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("bef_pre_clear", bef, 0);

      h = 16'(hh); w = 16'(ww); mode = md; dir = dd; src = sb; dst = db;
      start = 1'b1;
      clr   = hold_clr;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("new_h", new_h, (deg == 90 || deg == 270) ? ww : hh);
      chk("new_w", new_w, (deg == 90 || deg == 270) ? hh : ww);

      budget = total * 30 + 20;
      cyc = 0; nrd = 0; nwr = 0; vld_cycles = 0;
      rstall = stall; wstall = stall;
      fin = 0; aborted = 0; rd_wait = 0; wr_wait = 0;
      prev_rd_addr = '0; prev_wr_addr = '0; prev_wr_dat = '0;
      first_wr = 32'hFFFF_FFFF;

      while (!fin) begin
         if (!busy) begin
            fin = 1;
         end else if (cyc >= budget) begin
            chk("job_timeout", busy, 0);
            fin = 1;
         end else if (abort_at > 0 && nwr == abort_at) begin
            dma_if.rd_ready = 1'b0; dma_if.wr_ready = 1'b0; dma_if.rd_dvalid = 1'b0;
            start = 1'b0;
            soft_rst = 1'b1;
            @(negedge clk);
            soft_rst = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_rd_vld", dma_if.rd_valid, 0);
            chk("abort_wr_vld", dma_if.wr_valid, 0);
            chk("abort_bef", bef, 0);
            aborted = 1;
            fin = 1;
         end else begin
            // Start toggles while busy must be ignored
            start = 1'($urandom_range(0, 1));
            if (dma_if.rd_valid || dma_if.wr_valid) vld_cycles++;

            dma_if.rd_dvalid = 1'b0;
            if (lat_q.size() > 0) begin
               lat_q[0] = lat_q[0] - 1;
               if (lat_q[0] == 0) begin
                  void'(lat_q.pop_front());
                  dma_if.rd_dvalid = 1'b1;
                  dma_if.rd_data   = beat_q.pop_front();
               end
            end

            if (dma_if.rd_valid) begin
               if (rd_wait) chk("rd_addr_stable", dma_if.rd_addr, prev_rd_addr);
               if (rstall > 0) begin rdy = 0; rstall--; end
               else rdy = ($urandom_range(0, 3) != 0);
               dma_if.rd_ready = rdy;
               if (rdy) begin
                  chk("rd_in_range", nrd < total, 1);
                  if (nrd < total) chk("rd_addr", dma_if.rd_addr, exp_rd[nrd]);
                  beat_q.push_back(pix_data(dma_if.rd_addr));
                  lat_q.push_back(int'($urandom_range(1, 3)));
                  nrd++;
                  rd_wait = 0;
               end else begin
                  rd_wait = 1;
                  prev_rd_addr = dma_if.rd_addr;
               end
            end else begin
               dma_if.rd_ready = 1'($urandom_range(0, 1));
               rd_wait = 0;
            end

            if (dma_if.wr_valid) begin
               if (wr_wait) begin
                  chk("wr_addr_stable", dma_if.wr_addr, prev_wr_addr);
                  chk("wr_data_stable", dma_if.wr_data, prev_wr_dat);
               end
               if (wstall > 0) begin rdy = 0; wstall--; end
               else rdy = ($urandom_range(0, 3) != 0);
               dma_if.wr_ready = rdy;
               if (rdy) begin
                  chk("wr_in_range", nwr < total, 1);
                  if (nwr < total) begin
                     chk("wr_addr", dma_if.wr_addr, exp_wr[nwr]);
                     chk("wr_data", dma_if.wr_data, exp_dat[nwr]);
                  end
                  if (nwr == 0) first_wr = dma_if.wr_addr;
                  nwr++;
                  wr_wait = 0;
               end else begin
                  wr_wait = 1;
                  prev_wr_addr = dma_if.wr_addr;
                  prev_wr_dat  = dma_if.wr_data;
               end
            end else begin
               dma_if.wr_ready = 1'($urandom_range(0, 1));
               wr_wait = 0;
            end

            cyc++;
            @(negedge clk);
         end
      end

      start = 1'b0;
      dma_if.rd_ready = 1'b0; dma_if.wr_ready = 1'b0; dma_if.rd_dvalid = 1'b0;
      last_nrd = nrd;
      last_nwr = nwr;

      if (!aborted) begin
         chk("rd_count", nrd, total);
         chk("wr_count", nwr, total);
         chk("bef_done", bef, 1);
         chk("aft_done", aft, !mask);
         chk("rd_vld_idle", dma_if.rd_valid, 0);
         chk("wr_vld_idle", dma_if.wr_valid, 0);
         if (total == 0) begin
            chk("zero_no_valids", vld_cycles, 0);
            chk("zero_busy_len", (cyc >= 1 && cyc <= 2), 1);
         end
         if (hold_clr) begin
            @(negedge clk);
            clr = 1'b0;
            chk("bef_clr_after", bef, 0);
            chk("aft_clr_after", aft, 0);
         end
      end
      clr = 1'b0;
   endtask

   initial begin
      dma_if.rd_ready  = 1'b0;
      dma_if.rd_dvalid = 1'b0;
      dma_if.rd_data   = '0;
      dma_if.wr_ready  = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_bef", bef, 0);
      chk("rst_aft", aft, 0);
      chk("rst_rd_vld", dma_if.rd_valid, 0);
      chk("rst_wr_vld", dma_if.wr_valid, 0);
      chk("rst_new_h", new_h, 0);
      chk("rst_new_w", new_w, 0);
      chk("rst_rd_addr", dma_if.rd_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 90 CW on a 2x3 image
      run_job(2, 3, 2'd1, 1'b0, 32'h100, 32'h200, 0, 0, 0);
      chk("t1_first_wr", first_wr, 32'h204);
      chk("t1_new_w", new_w, 16'd2);

      // 90 CCW behaves as 270 CW
      run_job(2, 3, 2'd1, 1'b1, 32'h100, 32'h200, 0, 0, 0);
      chk("t2_first_wr", first_wr, 32'h210);
      chk("t2_new_h", new_h, 16'd3);

      // 180 with forced READY stalls
      run_job(5, 8, 2'd2, 1'b0, 32'h1000, 32'h8000, 0, 3, 0);
      chk("t3_reads", last_nrd, 40);
      chk("t3_writes", last_nwr, 40);
      chk("t3_first_wr", first_wr, 32'h809C);

      // Empty image
      run_job(0, 8, 2'd0, 1'b0, 32'h40, 32'h80, 0, 0, 0);

      // Soft abort after the third write, then a clean restart from pixel (0,0)
      run_job(3, 4, 2'd3, 1'b0, 32'h300, 32'h600, 3, 0, 0);
      chk("t5_abort_writes", last_nwr, 3);
      run_job(3, 4, 2'd3, 1'b0, 32'h300, 32'h600, 0, 0, 0);

      // Masked interrupt, clear held across DONE
      mask = 1'b1;
      run_job(2, 2, 2'd0, 1'b0, 32'h500, 32'h700, 0, 0, 1);
      mask = 1'b0;

      // Random images and rotations
      for (int k = 0; k < 8; k++) begin
         mask = 1'($urandom_range(0, 1));
         run_job(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 {$urandom_range(0, 255), 8'h00}, {$urandom_range(256, 511), 8'h00},
                 0, int'($urandom_range(0, 2)), 0);
      end
      mask = 1'b0;

      // Asynchronous reset in the middle of a transfer
      @(negedge clk);
      h = 16'd4; w = 16'd4; mode = 2'd1; dir = 1'b0; src = 32'h900; dst = 32'hA00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_arst_busy", busy, 1);
      chk("pre_arst_rd_vld", dma_if.rd_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_rd_vld", dma_if.rd_valid, 0);
      chk("arst_new_h", new_h, 0);
      chk("arst_bef", bef, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_arst_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
